// File: rtl/step_clock_ctrl_pkg.sv
// Shared definitions for the processor step/run clock controller.
package step_clock_ctrl_pkg;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] PULSE = 2'd1;
    localparam logic [1:0] RUN   = 2'd2;
    localparam logic [1:0] HALT  = 2'd3;

    localparam logic [15:0] EDGE_MAX = 16'hFFFF;

    // Width of a counter that must reach n-1; never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/step_clock_ctrl_key_debounce.sv
// Two-flop synchroniser plus debouncer: the output follows the input only after the
// synchronised input has disagreed with it for CYCLES consecutive clocks.
module key_debounce
    import step_clock_ctrl_pkg::*;
#(
    parameter int CYCLES = 500000
) (
    input  logic clock,
    input  logic reset,
    input  logic din_i,
    output logic dout_o
);
    localparam int            CW = cnt_w(CYCLES);
    localparam logic [CW-1:0] TC = CW'(CYCLES - 1);

    logic          sync1_q;
    logic          sync2_q;
    logic          dout_q;
    logic          dout_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= din_i;
            sync2_q <= sync1_q;
        end
    end

    // Any sample that agrees with the current output restarts the count.
    always_comb begin
        cnt_d  = '0;
        dout_d = dout_q;
        if (sync2_q != dout_q) begin
            if (cnt_q == TC) begin
                dout_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_q  <= '0;
            dout_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            dout_q <= dout_d;
        end
    end

    assign dout_o = dout_q;

endmodule

// File: rtl/step_clock_ctrl.sv
// Processor clock generator: debounced single-step pulses or a divided free-running
// clock, frozen permanently once the datapath requests a halt.
module step_clock_ctrl
    import step_clock_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int HIGH_CYCLES     = 4,
    parameter int RUN_HALF        = 25000000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        key_step_n_i,
    input  logic        sw_run_i,
    input  logic        stop_i,
    output logic        proc_clk_o,
    output logic        running_o,
    output logic        halted_o,
    output logic [15:0] edge_count_o
);
    localparam int            PW      = cnt_w((HIGH_CYCLES > RUN_HALF) ? HIGH_CYCLES : RUN_HALF);
    localparam logic [PW-1:0] HIGH_TC = PW'(HIGH_CYCLES - 1);
    localparam logic [PW-1:0] RUN_TC  = PW'(RUN_HALF - 1);

    logic          step_db;
    logic          run_db;
    logic          step_db_q;
    logic          step_evt;
    logic          stop_s1_q;
    logic          stop_s_q;

    logic [1:0]    state_q;
    logic [1:0]    state_d;
    logic [PW-1:0] phase_q;
    logic [PW-1:0] phase_d;
    logic          proc_clk_q;
    logic          proc_clk_d;
    logic [15:0]   edge_cnt_q;
    logic [15:0]   edge_cnt_d;
    logic          running_q;
    logic          halted_q;

    // Key is inverted up front so both debouncers treat 1 as pressed / active.
    key_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_step_db (
        .clock  (clock),
        .reset  (reset),
        .din_i  (~key_step_n_i),
        .dout_o (step_db)
    );

    key_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_run_db (
        .clock  (clock),
        .reset  (reset),
        .din_i  (sw_run_i),
        .dout_o (run_db)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stop_s1_q <= 1'b0;
            stop_s_q  <= 1'b0;
            step_db_q <= 1'b0;
        end else begin
            stop_s1_q <= stop_i;
            stop_s_q  <= stop_s1_q;
            step_db_q <= step_db;
        end
    end

    assign step_evt = step_db & ~step_db_q;

    always_comb begin
        state_d    = state_q;
        phase_d    = phase_q;
        proc_clk_d = proc_clk_q;
        case (state_q)
            IDLE: begin
                proc_clk_d = 1'b0;
                phase_d    = '0;
                if (stop_s_q) begin
                    state_d = HALT;
                end else if (run_db) begin
                    state_d = RUN;
                end else if (step_evt) begin
                    state_d    = PULSE;
                    proc_clk_d = 1'b1;
                end
            end
            PULSE: begin
                if (phase_q == HIGH_TC) begin
                    phase_d    = '0;
                    proc_clk_d = 1'b0;
                    state_d    = IDLE;
                end else begin
                    phase_d = phase_q + 1'b1;
                end
            end
            RUN: begin
                // Exits are only taken as a high phase ends, so no pulse is ever clipped.
                if (phase_q == RUN_TC) begin
                    phase_d    = '0;
                    proc_clk_d = ~proc_clk_q;
                    if (proc_clk_q) begin
                        if (stop_s_q) begin
                            state_d = HALT;
                        end else if (!run_db) begin
                            state_d = IDLE;
                        end
                    end
                end else begin
                    phase_d = phase_q + 1'b1;
                end
            end
            default: begin
                proc_clk_d = 1'b0;
                phase_d    = '0;
            end
        endcase
    end

    always_comb begin
        edge_cnt_d = edge_cnt_q;
        if (proc_clk_d && !proc_clk_q && (edge_cnt_q != EDGE_MAX)) begin
            edge_cnt_d = edge_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            phase_q    <= '0;
            proc_clk_q <= 1'b0;
            edge_cnt_q <= '0;
            running_q  <= 1'b0;
            halted_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            proc_clk_q <= proc_clk_d;
            edge_cnt_q <= edge_cnt_d;
            running_q  <= (state_d == RUN);
            halted_q   <= (state_d == HALT);
        end
    end

    assign proc_clk_o   = proc_clk_q;
    assign running_o    = running_q;
    assign halted_o     = halted_q;
    assign edge_count_o = edge_cnt_q;

endmodule

// File: tb/tb_step_clock_ctrl.sv
// Bench for step_clock_ctrl: timing expectations come from latency arithmetic
// (sync + debounce + FSM) and a phase-based model of the run clock.
module tb_step_clock_ctrl;
    localparam int DC = 4;
    localparam int HC = 2;
    localparam int RH = 3;
    localparam int ENTRY = 2 + DC + 1;

    logic        clock  = 1'b0;
    logic        reset  = 1'b0;
    logic        key_n  = 1'b1;
    logic        sw_run = 1'b0;
    logic        stop   = 1'b0;
    logic        proc_clk;
    logic        running;
    logic        halted;
    logic [15:0] edge_count;

    int   checks    = 0;
    int   errors    = 0;
    int   exp_edges = 0;
    int   rises     = 0;
    int   hi_run    = 0;
    int   last_hi   = 0;
    logic prev_clk  = 1'b0;

    step_clock_ctrl #(
        .DEBOUNCE_CYCLES (DC),
        .HIGH_CYCLES     (HC),
        .RUN_HALF        (RH)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .key_step_n_i (key_n),
        .sw_run_i     (sw_run),
        .stop_i       (stop),
        .proc_clk_o   (proc_clk),
        .running_o    (running),
        .halted_o     (halted),
        .edge_count_o (edge_count)
    );

    always #5 clock = ~clock;

    always @(negedge clock) begin
        prev_clk <= proc_clk;
        if (proc_clk && !prev_clk) rises <= rises + 1;
        if (proc_clk) hi_run <= hi_run + 1;
        else begin
            if (prev_clk) last_hi <= hi_run;
            hi_run <= 0;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    function automatic int sat_inc(input int v);
        return (v >= 65535) ? 65535 : v + 1;
    endfunction

    // Run clock seen e edges after entry: first rise RH after entry, 50% duty, until exit.
    function automatic logic exp_clk(input int t, input int e, input int ex);
        return (t >= e + RH) && (t < ex) && (((t - e - RH) % (2 * RH)) < RH);
    endfunction

    // First end of a high half-period whose decision sees a request visible after edge thr.
    function automatic int exit_edge(input int e, input int thr);
        int f;
        f = e + 2 * RH;
        while (f <= thr) f += 2 * RH;
        return f;
    endfunction

    task automatic test_reset();
        bit found;
        bit bad;
        reset = 1'b0;
        #2 reset = 1'b1;
        tick(3);
        @(negedge clock);
        checks++;
        if ({proc_clk, running, halted, edge_count} !== 19'd0) begin
            errors++;
            $display("FAIL reset_values: clk=%b run=%b halt=%b cnt=%0h want all 0",
                     proc_clk, running, halted, edge_count);
        end
        tick(1);
        reset = 1'b0;
        tick(2);
        key_n = 1'b0;
        tick(6);
        key_n = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clock);
            if (proc_clk === 1'b1) found = 1'b1;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL reset_pulse_wait: proc_clk=0 want a pulse before reset");
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({proc_clk, running, halted, edge_count} !== 19'd0) begin
            errors++;
            $display("FAIL reset_midpulse: clk=%b run=%b halt=%b cnt=%0h want all 0",
                     proc_clk, running, halted, edge_count);
        end
        tick(2);
        reset = 1'b0;
        exp_edges = 0;
        bad = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            if (proc_clk !== 1'b0 || running !== 1'b0 || halted !== 1'b0) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL reset_idle: outputs active after release, want idle");
        end
    endtask

    task automatic test_debounce();
        int  r0;
        logic want;
        tick(1);
        r0 = rises;
        key_n = 1'b0;
        tick(DC - 1);
        key_n = 1'b1;
        tick(15);
        checks++;
        if (rises != r0 || edge_count !== 16'(exp_edges)) begin
            errors++;
            $display("FAIL short_press: rises=%0d cnt=%0h want rises=%0d cnt=%0h",
                     rises, edge_count, r0, exp_edges);
        end
        key_n = 1'b0;
        for (int j = 1; j <= 12; j++) begin
            @(negedge clock);
            want = (j >= ENTRY + 1) && (j < ENTRY + 1 + HC);
            checks++;
            if (proc_clk !== want) begin
                errors++;
                $display("FAIL step_pulse_cycle%0d: proc_clk=%b want %b", j, proc_clk, want);
            end
            tick(1);
            if (j == 6) key_n = 1'b1;
        end
        exp_edges = sat_inc(exp_edges);
        tick(8);
        checks++;
        if (rises != r0 + 1 || last_hi != HC || edge_count !== 16'(exp_edges)) begin
            errors++;
            $display("FAIL step_pulse: rises=%0d hi=%0d cnt=%0h want rises=%0d hi=%0d cnt=%0h",
                     rises - r0, last_hi, edge_count, 1, HC, exp_edges);
        end
    endtask

    task automatic test_lockout();
        int r0;
        r0 = rises;
        key_n = 1'b0; tick(6);
        key_n = 1'b1; tick(2);
        key_n = 1'b0; tick(20);
        key_n = 1'b1; tick(15);
        exp_edges = sat_inc(exp_edges);
        checks++;
        if (rises != r0 + 1 || edge_count !== 16'(exp_edges)) begin
            errors++;
            $display("FAIL lockout_hold: rises=%0d cnt=%0h want rises=1 cnt=%0h",
                     rises - r0, edge_count, exp_edges);
        end
        key_n = 1'b0; tick(6);
        key_n = 1'b1; tick(15);
        exp_edges = sat_inc(exp_edges);
        checks++;
        if (rises != r0 + 2 || edge_count !== 16'(exp_edges)) begin
            errors++;
            $display("FAIL lockout_repress: rises=%0d cnt=%0h want rises=2 cnt=%0h",
                     rises - r0, edge_count, exp_edges);
        end
    endtask

    task automatic test_random_steps();
        int r0;
        int len;
        int want_r;
        for (int i = 0; i < 8; i++) begin
            r0  = rises;
            len = $urandom_range(1, 8);
            key_n = 1'b0; tick(len);
            key_n = 1'b1; tick($urandom_range(14, 18));
            want_r = (len >= DC) ? 1 : 0;
            if (want_r == 1) exp_edges = sat_inc(exp_edges);
            checks++;
            if (rises != r0 + want_r || edge_count !== 16'(exp_edges)) begin
                errors++;
                $display("FAIL rand_step%0d len=%0d: rises=%0d cnt=%0h want rises=%0d cnt=%0h",
                         i, len, rises - r0, edge_count, want_r, exp_edges);
            end
        end
    endtask

    task automatic test_run();
        int r0;
        int td;
        int ex;
        logic want_c;
        logic want_r;
        r0 = rises;
        td = ENTRY + 2 * RH * $urandom_range(0, 2) + $urandom_range(0, RH - 1);
        ex = exit_edge(ENTRY, td + 2 + DC);
        sw_run = 1'b1;
        for (int t = 0; t <= ex + 6; t++) begin
            @(negedge clock);
            want_c = exp_clk(t, ENTRY, ex);
            want_r = (t >= ENTRY) && (t < ex);
            checks++;
            if (proc_clk !== want_c) begin
                errors++;
                $display("FAIL run_clk_t%0d: proc_clk=%b want %b (drop %0d)", t, proc_clk, want_c, td);
            end
            checks++;
            if (running !== want_r) begin
                errors++;
                $display("FAIL run_flag_t%0d: running=%b want %b", t, running, want_r);
            end
            tick(1);
            if (t + 1 == td) sw_run = 1'b0;
        end
        for (int i = 0; i < (ex - ENTRY) / (2 * RH); i++) exp_edges = sat_inc(exp_edges);
        checks++;
        if (rises != r0 + (ex - ENTRY) / (2 * RH) || edge_count !== 16'(exp_edges)) begin
            errors++;
            $display("FAIL run_edges: rises=%0d cnt=%0h want rises=%0d cnt=%0h",
                     rises - r0, edge_count, (ex - ENTRY) / (2 * RH), exp_edges);
        end
    endtask

    task automatic test_halt();
        int r0;
        int ts;
        int ex;
        logic want_c;
        tick(4);
        r0 = rises;
        ts = ENTRY + RH + 2 * RH * $urandom_range(0, 2) + $urandom_range(0, RH - 1);
        ex = exit_edge(ENTRY, ts + 2);
        sw_run = 1'b1;
        for (int t = 0; t <= ex + 4; t++) begin
            @(negedge clock);
            want_c = exp_clk(t, ENTRY, ex);
            checks++;
            if (proc_clk !== want_c || running !== (t >= ENTRY && t < ex) || halted !== (t >= ex)) begin
                errors++;
                $display("FAIL halt_t%0d: clk=%b run=%b halt=%b want %b %b %b (stop %0d)",
                         t, proc_clk, running, halted, want_c, (t >= ENTRY && t < ex), (t >= ex), ts);
            end
            tick(1);
            if (t + 1 == ts) stop = 1'b1;
        end
        for (int i = 0; i < (ex - ENTRY) / (2 * RH); i++) exp_edges = sat_inc(exp_edges);
        checks++;
        if (edge_count !== 16'(exp_edges)) begin
            errors++;
            $display("FAIL halt_edges: cnt=%0h want %0h", edge_count, exp_edges);
        end
        r0 = rises;
        stop = 1'b0; sw_run = 1'b0; tick(8);
        key_n = 1'b0; tick(6); key_n = 1'b1; tick(10);
        sw_run = 1'b1; tick(12);
        key_n = 1'b0; tick(6); key_n = 1'b1; tick(10);
        @(negedge clock);
        checks++;
        if (rises != r0 || proc_clk !== 1'b0 || halted !== 1'b1 || running !== 1'b0) begin
            errors++;
            $display("FAIL halt_sticky: rises=%0d clk=%b halt=%b run=%b want 0 0 1 0",
                     rises - r0, proc_clk, halted, running);
        end
        checks++;
        if (edge_count !== 16'(exp_edges)) begin
            errors++;
            $display("FAIL halt_count_hold: cnt=%0h want %0h", edge_count, exp_edges);
        end
        reset = 1'b1;
        #1;
        checks++;
        if (halted !== 1'b0) begin
            errors++;
            $display("FAIL halt_reset: halted=%b want 0", halted);
        end
        sw_run = 1'b0;
        tick(2);
        reset = 1'b0;
        exp_edges = 0;
        tick(10);
    endtask

    task automatic test_saturation();
        int r0;
        @(negedge clock);
        force dut.edge_cnt_q = 16'hFFFE;
        tick(1);
        release dut.edge_cnt_q;
        exp_edges = 16'hFFFE;
        @(negedge clock);
        checks++;
        if (edge_count !== 16'(exp_edges)) begin
            errors++;
            $display("FAIL sat_preload: cnt=%0h want %0h", edge_count, exp_edges);
        end
        tick(1);
        for (int i = 0; i < 3; i++) begin
            r0 = rises;
            key_n = 1'b0; tick(6);
            key_n = 1'b1; tick(14);
            exp_edges = sat_inc(exp_edges);
            checks++;
            if (rises != r0 + 1 || edge_count !== 16'(exp_edges)) begin
                errors++;
                $display("FAIL sat_step%0d: rises=%0d cnt=%0h want rises=1 cnt=%0h",
                         i, rises - r0, edge_count, exp_edges);
            end
        end
    endtask

    initial begin
        test_reset();
        test_debounce();
        test_lockout();
        test_random_steps();
        test_run();
        test_halt();
        test_saturation();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
